uart_tx_arbiter: RTL and testbench

- Shares one uart_byte_tx instance among NUM_REQ byte-stream requesters, such as str_ctrl instances or status reporters.
- Grants at packet granularity: once a requester wins, it keeps the transmitter until it hands over a byte flagged Last, or until it stalls past a timeout.
- Arbitration between packets is round-robin.
- Sits between the requesters and uart_byte_tx in the uart_tx top level.

---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one uart_byte_tx among
// NUM_REQ byte-stream requesters, revoking a grant that stalls mid-packet.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned GAP_TIMEOUT = 50_000_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   i_REQ_Valid,
    input  logic [8*NUM_REQ-1:0] i_REQ_Data,
    input  logic [NUM_REQ-1:0]   i_REQ_Last,
    output logic [NUM_REQ-1:0]   o_REQ_Ready,
    output logic [7:0]           o_TXD_Din,
    output logic                 o_TXD_En,
    input  logic                 i_TXD_Done,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Abort,
    output logic [15:0]          o_Pkt_Cnt
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             sel_found;
    logic             last_r;
    logic             hs;
    logic [CNT_W-1:0] gap_cnt;
    logic [15:0]      pkt_cnt;
    logic [7:0]       req_byte;

    // First valid requester scanning upward from the pointer, with wrap.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!sel_found && i_REQ_Valid[PTR_W'(idx)]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        hs          = (state == LOAD) && i_REQ_Valid[gnt_idx];
        req_byte    = i_REQ_Data[{gnt_idx, 3'b000} +: 8];
        next_ptr    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        o_REQ_Ready = (state == LOAD) ? o_Grant : '0;
        o_Pkt_Cnt   = pkt_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            o_Grant   <= '0;
            o_TXD_Din <= '0;
            o_TXD_En  <= 1'b0;
            o_Abort   <= 1'b0;
            last_r    <= 1'b0;
            gap_cnt   <= '0;
            pkt_cnt   <= '0;
        end else begin
            o_TXD_En <= 1'b0;
            o_Abort  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        gnt_idx <= sel_idx;
                        o_Grant <= NUM_REQ'(1) << sel_idx;
                        gap_cnt <= '0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        o_TXD_Din <= req_byte;
                        last_r    <= i_REQ_Last[gnt_idx];
                        o_TXD_En  <= 1'b1;
                        gap_cnt   <= '0;
                        state     <= WAIT;
                    end else if (gap_cnt == CNT_W'(GAP_TIMEOUT - 1)) begin
                        o_Abort <= 1'b1;
                        o_Grant <= '0;
                        ptr     <= next_ptr;
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (i_TXD_Done) begin
                        gap_cnt <= '0;
                        if (last_r) begin
                            pkt_cnt <= pkt_cnt + 16'd1;
                            ptr     <= next_ptr;
                            o_Grant <= '0;
                            state   <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a delayed-Done
// transmitter model driven at the falling edge, checked with immediate asserts.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  i_REQ_Valid;
    logic [8*N-1:0] i_REQ_Data;
    logic [N-1:0]  i_REQ_Last;
    logic [N-1:0]  o_REQ_Ready;
    logic [7:0]    o_TXD_Din;
    logic          o_TXD_En;
    logic          i_TXD_Done;
    logic [N-1:0]  o_Grant;
    logic          o_Abort;
    logic [15:0]   o_Pkt_Cnt;

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .GAP_TIMEOUT(16),
        .CNT_W      (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_REQ_Valid(i_REQ_Valid),
        .i_REQ_Data (i_REQ_Data),
        .i_REQ_Last (i_REQ_Last),
        .o_REQ_Ready(o_REQ_Ready),
        .o_TXD_Din  (o_TXD_Din),
        .o_TXD_En   (o_TXD_En),
        .i_TXD_Done (i_TXD_Done),
        .o_Grant    (o_Grant),
        .o_Abort    (o_Abort),
        .o_Pkt_Cnt  (o_Pkt_Cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Requester byte queues: bit 8 is the Last flag.
    logic [8:0] rq [N][$];
    logic [7:0] din_log [$];
    logic [3:0] gnt_log [$];
    int   en_cnt, abort_cnt, cyc, timer, done_dly, done_cyc, abort_cyc;
    logic force_done;
    logic [N-1:0] hs_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One falling edge: log En/Abort, run the Done model, advance requester queues.
    task automatic step();
        logic fire;
        @(negedge clk);
        cyc++;
        fire = 1'b0;
        if (o_TXD_En) begin
            en_cnt++;
            din_log.push_back(o_TXD_Din);
            gnt_log.push_back(o_Grant);
            timer = done_dly;
        end else if (timer > 0) begin
            timer--;
            fire = (timer == 0);
        end
        if (o_Abort) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if (fire) done_cyc = cyc;
        i_TXD_Done = fire | force_done;
        force_done = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (hs_prev[k] && rq[k].size() > 0) rq[k].delete(0);
            if (rq[k].size() > 0) begin
                i_REQ_Valid[k]        = 1'b1;
                i_REQ_Data[8*k +: 8]  = rq[k][0][7:0];
                i_REQ_Last[k]         = rq[k][0][8];
            end else begin
                i_REQ_Valid[k]        = 1'b0;
                i_REQ_Data[8*k +: 8]  = 8'h00;
                i_REQ_Last[k]         = 1'b0;
            end
        end
        hs_prev = i_REQ_Valid & o_REQ_Ready;
    endtask

    task automatic clear_logs();
        en_cnt = 0;
        abort_cnt = 0;
        din_log.delete();
        gnt_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) rq[k].delete();
        timer = 0;
        hs_prev = '0;
        force_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while (!(rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
                 rq[3].size() == 0 && timer == 0 && o_Grant == '0 && !o_TXD_En) && n < max) begin
            step();
            n++;
        end
        chk({tag, "_drain_bound"}, 32'(n < max), 1);
    endtask

    initial begin
        int n;
        i_REQ_Valid = '0;
        i_REQ_Data = '0;
        i_REQ_Last = '0;
        i_TXD_Done = 1'b0;
        cyc = 0; timer = 0; done_dly = 10; done_cyc = 0; abort_cyc = 0;
        force_done = 1'b0;
        hs_prev = '0;
        clear_logs();

        // Reset state and single packet with latency checks
        do_reset();
        chk("rst_grant", o_Grant, 0);
        chk("rst_din", o_TXD_Din, 0);
        chk("rst_en", o_TXD_En, 0);
        chk("rst_abort", o_Abort, 0);
        chk("rst_pkt", o_Pkt_Cnt, 0);
        chk("rst_ready", o_REQ_Ready, 0);
        done_dly = 10;
        rq[0].push_back(9'h041);
        rq[0].push_back(9'h042);
        rq[0].push_back(9'h143);
        step();
        chk("lat_ready_t", o_REQ_Ready, 4'b0000);
        step();
        chk("lat_ready_t1", o_REQ_Ready, 4'b0001);
        chk("lat_en_t1", o_TXD_En, 0);
        step();
        chk("lat_en_t2", o_TXD_En, 1);
        chk("lat_din_t2", o_TXD_Din, 8'h41);
        drain("single", 200);
        chk("single_en_cnt", en_cnt, 3);
        chk("single_din0", din_log[0], 8'h41);
        chk("single_din1", din_log[1], 8'h42);
        chk("single_din2", din_log[2], 8'h43);
        for (int i = 0; i < 3; i++) chk($sformatf("single_gnt%0d", i), gnt_log[i], 4'b0001);
        chk("single_pkt", o_Pkt_Cnt, 1);

        // Round-robin: req1 then req3, no interleave; pointer wraps to 0
        do_reset();
        done_dly = 3;
        rq[1].push_back(9'h011); rq[1].push_back(9'h112);
        rq[3].push_back(9'h031); rq[3].push_back(9'h132);
        drain("rr", 200);
        chk("rr_en_cnt", en_cnt, 4);
        chk("rr_din0", din_log[0], 8'h11);
        chk("rr_din1", din_log[1], 8'h12);
        chk("rr_din2", din_log[2], 8'h31);
        chk("rr_din3", din_log[3], 8'h32);
        chk("rr_gnt1", gnt_log[1], 4'b0010);
        chk("rr_gnt2", gnt_log[2], 4'b1000);
        chk("rr_pkt", o_Pkt_Cnt, 2);
        rq[0].push_back(9'h1A0);
        rq[1].push_back(9'h1B1);
        drain("rr_ptr", 200);
        chk("rr_ptr_gnt4", gnt_log[4], 4'b0001);
        chk("rr_ptr_din4", din_log[4], 8'hA0);
        chk("rr_ptr_gnt5", gnt_log[5], 4'b0010);
        chk("rr_ptr_pkt", o_Pkt_Cnt, 4);

        // Fairness: req0 and req2 each stream three 1-byte packets
        do_reset();
        done_dly = 2;
        for (int i = 0; i < 3; i++) begin
            rq[0].push_back(9'h1C0 + 9'(i));
            rq[2].push_back(9'h1E0 + 9'(i));
        end
        drain("fair", 300);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fair_gnt%0d", i), gnt_log[i], (i % 2 == 1) ? 4'b0100 : 4'b0001);
            chk($sformatf("fair_din%0d", i), din_log[i],
                8'(((i % 2 == 1) ? 8'hE0 : 8'hC0) + 8'(i / 2)));
        end
        chk("fair_pkt", o_Pkt_Cnt, 6);

        // Gap timeout: req2 stalls after one non-Last byte, req3 waits
        do_reset();
        done_dly = 3;
        rq[2].push_back(9'h055);
        rq[3].push_back(9'h166);
        n = 0;
        while (!o_Abort && n < 100) begin
            step();
            n++;
        end
        chk("to_abort_bound", 32'(n < 100), 1);
        chk("to_abort_delay", abort_cyc - done_cyc, 17);
        chk("to_grant_clear", o_Grant, 4'b0000);
        chk("to_pkt_same", o_Pkt_Cnt, 0);
        chk("to_din0", din_log[0], 8'h55);
        step();
        chk("to_abort_pulse", o_Abort, 0);
        chk("to_next_grant", o_Grant, 4'b1000);
        drain("to", 200);
        chk("to_pkt", o_Pkt_Cnt, 1);
        chk("to_din1", din_log[1], 8'h66);
        chk("to_abort_cnt", abort_cnt, 1);

        // Asynchronous reset while in WAIT
        clear_logs();
        done_dly = 30;
        rq[0].push_back(9'h177);
        n = 0;
        while (en_cnt == 0 && n < 20) begin
            step();
            n++;
        end
        chk("ar_en_bound", 32'(n < 20), 1);
        step(); step(); step();
        chk("ar_pre_grant", o_Grant, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_grant", o_Grant, 0);
        chk("ar_din", o_TXD_Din, 0);
        chk("ar_en", o_TXD_En, 0);
        chk("ar_abort", o_Abort, 0);
        chk("ar_pkt", o_Pkt_Cnt, 0);
        timer = 0;
        hs_prev = '0;
        step(); step();
        rst_n = 1'b1;
        clear_logs();
        done_dly = 3;
        rq[0].push_back(9'h178);
        drain("ar", 200);
        chk("ar_post_pkt", o_Pkt_Cnt, 1);
        chk("ar_post_din", din_log[0], 8'h78);
        chk("ar_post_en", en_cnt, 1);

        // Spurious Done in IDLE and in LOAD
        force_done = 1'b1;
        step(); step();
        chk("sp_idle_grant", o_Grant, 0);
        chk("sp_idle_pkt", o_Pkt_Cnt, 1);
        chk("sp_idle_en", en_cnt, 1);
        rq[1].push_back(9'h021);
        n = 0;
        while (en_cnt == 1 && n < 20) begin
            step();
            n++;
        end
        chk("sp_en_bound", 32'(n < 20), 1);
        step(); step(); step(); step();
        chk("sp_in_load", o_REQ_Ready, 4'b0010);
        force_done = 1'b1;
        step(); step();
        chk("sp_load_grant", o_Grant, 4'b0010);
        chk("sp_load_ready", o_REQ_Ready, 4'b0010);
        chk("sp_load_pkt", o_Pkt_Cnt, 1);
        chk("sp_load_en", en_cnt, 2);
        rq[1].push_back(9'h122);
        drain("sp", 200);
        chk("sp_pkt", o_Pkt_Cnt, 2);
        chk("sp_din", din_log[2], 8'h22);

        // Packet counter wrap from 0xFFFF
        dut.pkt_cnt = 16'hFFFF;
        step();
        chk("wrap_pre", o_Pkt_Cnt, 16'hFFFF);
        rq[2].push_back(9'h1F0);
        drain("wrap", 200);
        chk("wrap_pkt", o_Pkt_Cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
